// File: rtl/cory_sram_req2port.sv
// Request/response adapter onto one cen/wen/oen SRAM arbiter port with a credit-protected read FIFO.
// Optional macro CORY_SRAM_REQ2PORT_BYPASS_EN: forward read data straight to the consumer when the FIFO is empty.
module cory_sram_req2port #(
  parameter int A     = 8,
  parameter int D     = 16,
  parameter int C     = 2,
  parameter int R     = D * C,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_a_v,
  input  logic                       i_a_wr,
  input  logic [C-1:0]               i_a_col,
  input  logic [A-1:0]               i_a_addr,
  input  logic [D-1:0]               i_a_wdata,
  output logic                       o_a_r,
  output logic [C-1:0]               o_z_cen,
  output logic [C-1:0]               o_z_wen,
  output logic [C-1:0]               o_z_oen,
  output logic [A-1:0]               o_z_addr,
  output logic [D-1:0]               o_z_wdata,
  input  logic [R-1:0]               i_z_rdata,
  input  logic                       i_z_r,
  output logic                       o_b_v,
  output logic [R-1:0]               o_b_data,
  input  logic                       i_b_r,
  output logic [$clog2(DEPTH):0]     o_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic           r_pend_p1;
  logic [C-1:0]   r_pend_col_p1;
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic [R-1:0]   r_mem [DEPTH];

  logic [CW-1:0]  w_occ;
  logic [CW-1:0]  w_cnt;
  logic           w_iss;
  logic           w_acc_rd;
  logic           w_empty;
  logic           w_byp;
  logic           w_push;
  logic           w_pop;

  // Credit counts reads in flight, so a read is only issued when its data has a guaranteed slot.
  assign w_occ    = r_wptr - r_rptr;
  assign w_cnt    = w_occ + {{(CW-1){1'b0}}, r_pend_p1};
  assign w_iss    = i_a_v & (i_a_wr | (w_cnt < CW'(DEPTH)));
  assign w_acc_rd = i_a_v & o_a_r & ~i_a_wr;
  assign w_empty  = (r_wptr == r_rptr);

`ifdef CORY_SRAM_REQ2PORT_BYPASS_EN
  assign w_byp = r_pend_p1 & w_empty & i_b_r;
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = r_pend_p1 & ~w_byp;
  assign w_pop  = ~w_empty & i_b_r;

  // Issue stage (p0): combinational request onto the arbiter port
  assign o_a_r     = w_iss & i_z_r;
  assign o_z_cen   = w_iss ? ~i_a_col : {C{1'b1}};
  assign o_z_wen   = (w_iss & i_a_wr) ? ~i_a_col : {C{1'b1}};
  assign o_z_addr  = i_a_addr;
  assign o_z_wdata = i_a_wdata;
  assign o_cnt     = w_cnt;

  // Data-return stage (p1): read data sampled while pend is set
  assign o_z_oen  = r_pend_p1 ? ~r_pend_col_p1 : {C{1'b1}};
  assign o_b_v    = ~w_empty | w_byp;
  assign o_b_data = w_byp ? i_z_rdata : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_p1 <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      r_pend_p1 <= w_acc_rd;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc_rd) r_pend_col_p1 <= i_a_col;
    if (w_push)   r_mem[r_wptr[AW-1:0]] <= i_z_rdata;
  end

endmodule

// File: tb/tb_cory_sram_req2port.sv
// Directed bench for cory_sram_req2port; expectations follow CORY_SRAM_REQ2PORT_BYPASS_EN if defined.
module tb_cory_sram_req2port;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_a_v, i_a_wr, i_z_r, i_b_r;
  logic [1:0]  i_a_col;
  logic [7:0]  i_a_addr;
  logic [15:0] i_a_wdata;
  logic [31:0] i_z_rdata;
  logic        o_a_r, o_b_v;
  logic [1:0]  o_z_cen, o_z_wen, o_z_oen;
  logic [7:0]  o_z_addr;
  logic [15:0] o_z_wdata;
  logic [31:0] o_b_data;
  logic [2:0]  o_cnt;

  int errors = 0;
  int checks = 0;

  cory_sram_req2port dut (
    .clk(clk), .reset(reset),
    .i_a_v(i_a_v), .i_a_wr(i_a_wr), .i_a_col(i_a_col), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
    .o_a_r(o_a_r), .o_z_cen(o_z_cen), .o_z_wen(o_z_wen), .o_z_oen(o_z_oen),
    .o_z_addr(o_z_addr), .o_z_wdata(o_z_wdata), .i_z_rdata(i_z_rdata), .i_z_r(i_z_r),
    .o_b_v(o_b_v), .o_b_data(o_b_data), .i_b_r(i_b_r), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Occupancy can never exceed DEPTH; a read landing in a full FIFO shows up as cnt = DEPTH+1.
  always @(negedge clk) begin
    if (!reset) assert (o_cnt <= 3'd4) else $error("FAIL fifo_overflow: cnt=%0d", o_cnt);
  end

  typedef struct {
    logic        av;
    logic        wr;
    logic [1:0]  col;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        zr;
    logic [31:0] rd;
    logic        br;
    logic        ar;
    logic [1:0]  cen;
    logic [1:0]  wen;
    logic [1:0]  oen;
    logic        bv;
    logic [31:0] bd;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic av, input logic wr, input logic [1:0] col, input logic [7:0] addr,
                     input logic [15:0] wd, input logic zr, input logic [31:0] rd, input logic br);
    i_a_v = av; i_a_wr = wr; i_a_col = col; i_a_addr = addr; i_a_wdata = wd;
    i_z_r = zr; i_z_rdata = rd; i_b_r = br;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_cen"}, 32'(o_z_cen), 32'h3);
    chk({nm, "_wen"}, 32'(o_z_wen), 32'h3);
    chk({nm, "_oen"}, 32'(o_z_oen), 32'h3);
    chk({nm, "_ar"},  32'(o_a_r),   32'h0);
    chk({nm, "_bv"},  32'(o_b_v),   32'h0);
    chk({nm, "_cnt"}, 32'(o_cnt),   32'h0);
  endtask

  initial begin
    int exp_cnt_fill [12];
    logic [31:0] exp_bd_fill [12];

    // Table: basic write, read latency, lost grant on a write
    tbl[0] = '{1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 32'h0,         1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 1'b0, 32'h0, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 2'b01, 8'h12, 16'hBEEF, 1'b1, 32'h0,         1'b1, 1'b1, 2'b10, 2'b10, 2'b11, 1'b0, 32'h0, 3'd0};
    tbl[2] = tbl[0];
    tbl[3] = '{1'b1, 1'b0, 2'b11, 8'h12, 16'h0000, 1'b1, 32'h0,         1'b1, 1'b1, 2'b00, 2'b11, 2'b11, 1'b0, 32'h0, 3'd0};
`ifdef CORY_SRAM_REQ2PORT_BYPASS_EN
    tbl[4] = '{1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 32'h12345678, 1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 32'h12345678, 3'd1};
    tbl[5] = tbl[0];
`else
    tbl[4] = '{1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 32'h12345678, 1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 32'h0, 3'd1};
    tbl[5] = '{1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 32'h0,         1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 1'b1, 32'h12345678, 3'd1};
`endif
    tbl[6] = tbl[0];
    tbl[7] = '{1'b1, 1'b1, 2'b10, 8'h56, 16'h0A0A, 1'b0, 32'h0,         1'b1, 1'b0, 2'b01, 2'b01, 2'b11, 1'b0, 32'h0, 3'd0};
    tbl[8] = '{1'b1, 1'b1, 2'b10, 8'h56, 16'h0A0A, 1'b1, 32'h0,         1'b1, 1'b1, 2'b01, 2'b01, 2'b11, 1'b0, 32'h0, 3'd0};
    tbl[9] = tbl[0];

    // Reset and idle
    drv(1'b0, 1'b0, 2'b00, 8'h00, 16'h0, 1'b1, 32'h0, 1'b1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk_idle("idle");
      tick();
    end

    for (int i = 0; i < 10; i++) begin
      drv(tbl[i].av, tbl[i].wr, tbl[i].col, tbl[i].addr, tbl[i].wd, tbl[i].zr, tbl[i].rd, tbl[i].br);
      settle();
      chk($sformatf("vec%0d_ar", i),  32'(o_a_r),   32'(tbl[i].ar));
      chk($sformatf("vec%0d_cen", i), 32'(o_z_cen), 32'(tbl[i].cen));
      chk($sformatf("vec%0d_wen", i), 32'(o_z_wen), 32'(tbl[i].wen));
      chk($sformatf("vec%0d_oen", i), 32'(o_z_oen), 32'(tbl[i].oen));
      chk($sformatf("vec%0d_bv", i),  32'(o_b_v),   32'(tbl[i].bv));
      chk($sformatf("vec%0d_cnt", i), 32'(o_cnt),   32'(tbl[i].cnt));
      if (tbl[i].bv) chk($sformatf("vec%0d_bd", i), o_b_data, tbl[i].bd);
      if (tbl[i].cen != 2'b11) begin
        chk($sformatf("vec%0d_addr", i),  32'(o_z_addr),  32'(tbl[i].addr));
        chk($sformatf("vec%0d_wdata", i), 32'(o_z_wdata), 32'(tbl[i].wd));
      end
      tick();
    end

    // Fill to credit limit with consumer stalled, then drain in order
    exp_cnt_fill = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 2, 1, 0};
    exp_bd_fill  = '{32'h0, 32'h0, 32'hD00D0001, 32'hD00D0001, 32'hD00D0001, 32'hD00D0001,
                     32'hD00D0001, 32'hD00D0002, 32'hD00D0003, 32'hD00D0004, 32'hD00D0008, 32'h0};
    for (int s = 0; s < 12; s++) begin
      drv(s < 8, 1'b0, 2'b11, 8'(s), 16'h0, 1'b1, {16'hD00D, 16'(s)}, s >= 6);
      settle();
      chk($sformatf("fill%0d_cnt", s), 32'(o_cnt), 32'(exp_cnt_fill[s]));
      if (s < 8) chk($sformatf("fill%0d_ar", s), 32'(o_a_r), 32'((s < 4) || (s == 7)));
      chk($sformatf("fill%0d_bv", s), 32'(o_b_v), 32'((s >= 2) && (s <= 10)));
      if (s >= 2 && s <= 10) chk($sformatf("fill%0d_bd", s), o_b_data, exp_bd_fill[s]);
      tick();
    end

    // Lost grant on a pending read
    for (int g = 0; g < 3; g++) begin
      drv(1'b1, 1'b0, 2'b01, 8'h34, 16'h0, 1'b0, 32'h0, 1'b1);
      settle();
      chk($sformatf("lost%0d_ar", g),   32'(o_a_r),    32'h0);
      chk($sformatf("lost%0d_cen", g),  32'(o_z_cen),  32'h2);
      chk($sformatf("lost%0d_addr", g), 32'(o_z_addr), 32'h34);
      chk($sformatf("lost%0d_oen", g),  32'(o_z_oen),  32'h3);
      tick();
    end
    drv(1'b1, 1'b0, 2'b01, 8'h34, 16'h0, 1'b1, 32'h0, 1'b1);
    settle();
    chk("grant_ar", 32'(o_a_r), 32'h1);
    chk("grant_cen", 32'(o_z_cen), 32'h2);
    tick();
    drv(1'b0, 1'b0, 2'b00, 8'h00, 16'h0, 1'b1, 32'hCAFEF00D, 1'b1);
    settle();
    chk("lostret_oen", 32'(o_z_oen), 32'h2);
`ifdef CORY_SRAM_REQ2PORT_BYPASS_EN
    chk("lostret_bv", 32'(o_b_v), 32'h1);
    chk("lostret_bd", o_b_data, 32'hCAFEF00D);
`else
    chk("lostret_bv", 32'(o_b_v), 32'h0);
`endif
    tick();
    i_z_rdata = 32'h0;
    settle();
`ifdef CORY_SRAM_REQ2PORT_BYPASS_EN
    chk("lostret2_bv", 32'(o_b_v), 32'h0);
`else
    chk("lostret2_bv", 32'(o_b_v), 32'h1);
    chk("lostret2_bd", o_b_data, 32'hCAFEF00D);
`endif
    tick();
    settle();
    chk_idle("lostend");
    tick();

    // Reset during the data-return cycle of a read
    drv(1'b1, 1'b0, 2'b11, 8'h77, 16'h0, 1'b1, 32'h0, 1'b0);
    settle();
    chk("rstrd_ar", 32'(o_a_r), 32'h1);
    tick();
    drv(1'b0, 1'b0, 2'b00, 8'h00, 16'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    reset = 1'b1;
    settle();
    chk("rstmid_oen", 32'(o_z_oen), 32'h0);
    tick();
    reset = 1'b0;
    i_b_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk_idle($sformatf("postrst%0d", k));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
